imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter N, default 32: width of program_counter and mem_addr, in bits.
REQ-002 Parameter H, default 16: depth of the instruction memory, in 32-bit words.
REQ-003 clk  input  1  the single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin a program load; sampled only in IDLE.
REQ-006 len_words  input  8  number of words to load; sampled with start.
REQ-007 byte_in  input  8  program byte stream, little-endian within each word.
REQ-008 byte_valid  input  1  byte_in holds a valid byte.
REQ-009 byte_ready  output  1  loader accepts byte_in in this cycle.
REQ-010 program_counter  input  N  core fetch byte address.
REQ-011 mem_addr  output  N  byte address to the instruction memory.
REQ-012 mem_wdata  output  32  write word to the instruction memory.
REQ-013 mem_we  output  1  write strobe to the instruction memory.
REQ-014 core_stall  output  1  holds the core; PC must not advance while high.
REQ-015 busy  output  1  a load is in progress.
REQ-016 done  output  1  one-cycle pulse when the last word has been written.
REQ-017 error  output  1  sticky flag: the last start had an illegal len_words.

Function
REQ-018 The loader SHALL be a state machine with states IDLE, RECV, WRITE and DONE.
REQ-019 IDLE: mem_addr SHALL equal program_counter combinationally; core_stall=0; busy=0; mem_we=0.
REQ-020 IDLE with start=1 and len_words in 1..H: clear error, latch len_words, set word_idx=0 and byte_idx=0, then go to RECV.
REQ-021 IDLE with start=1 and len_words=0 or len_words>H: set error=1, stay in IDLE, issue no writes.
REQ-022 RECV: byte_ready=1; a byte is accepted only when byte_valid=1 and byte_ready=1 in the same cycle.
REQ-023 An accepted byte SHALL be stored in word bits [8*byte_idx+7 : 8*byte_idx], and byte_idx SHALL increment modulo 4.
REQ-024 Cycles with byte_valid=0 SHALL leave all loader state unchanged.
REQ-025 Acceptance of the 4th byte (byte_idx=3) SHALL move the FSM to WRITE on the next edge.
REQ-026 WRITE lasts exactly one cycle:
- mem_we=1
- mem_addr = word_idx*4, zero-extended to N bits
- mem_wdata = the assembled word
- byte_ready=0
REQ-027 Leaving WRITE: if word_idx+1 equals the latched length, go to DONE; otherwise increment word_idx and return to RECV.
REQ-028 DONE lasts exactly one cycle with done=1, then the FSM returns to IDLE.
REQ-029 In RECV, WRITE and DONE: core_stall=1 and busy=1; mem_addr = word_idx*4 and mem_we=0, except in WRITE.
REQ-030 start asserted outside IDLE SHALL be ignored.
REQ-031 mem_wdata SHALL be 0 in every state except WRITE.
REQ-032 Write latency: WRITE occurs exactly 1 cycle after the 4th byte of a word is accepted.
REQ-033 Total load time with byte_valid held at 1: 5*len_words + 2 cycles from the start edge until done.

Reset
REQ-034 reset=1 SHALL force IDLE and clear byte_ready, mem_we, mem_wdata, core_stall, busy, done, error, word_idx and byte_idx.
REQ-035 reset takes priority over start and over any byte handshake in the same cycle.
REQ-036 reset mid-load SHALL discard the partially assembled word and SHALL NOT produce a write.
REQ-037 After reset, mem_addr SHALL follow program_counter.

Verification
REQ-038 Normal load: start with len=2, bytes 13 00 60 00 93 00 10 00 -> mem_we at addr 0x0 with 0x00600013, then addr 0x4 with 0x00100093; done pulse one cycle after the second write; core_stall falls with the return to IDLE.
REQ-039 Illegal length: start with len=0, then start with len=17 -> error=1 each time, no mem_we, core_stall=0; a following start with len=1 clears error.
REQ-040 Stalled stream: byte_valid toggled 1,0,0,1,1,0,1 -> same word and address as a gap-free stream; no write before the 4th accepted byte.
REQ-041 Reset mid-word: reset after 2 accepted bytes -> no mem_we; a new load then writes its first word at addr 0x0 built from fresh bytes 0..3.
REQ-042 Start while busy: pulse start with len=5 during a len=1 load -> exactly 1 write and 1 done pulse.
REQ-043 Full depth: len=16 -> 16 writes at addresses 0x00..0x3C in order; mem_addr follows program_counter after done.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: receives a little-endian byte stream, packs it into 32-bit
// words and writes them into the instruction memory while holding the core
// stalled. When idle, the memory address port is handed back to the core's
// program counter.
module imem_loader #(
    parameter int N = 32,
    parameter int H = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [7:0]   len_words,
    input  logic [7:0]   byte_in,
    input  logic         byte_valid,
    output logic         byte_ready,
    input  logic [N-1:0] program_counter,
    output logic [N-1:0] mem_addr,
    output logic [31:0]  mem_wdata,
    output logic         mem_we,
    output logic         core_stall,
    output logic         busy,
    output logic         done,
    output logic         error
);

    // Widened copy of the depth so len_words can be compared without
    // truncating either side.
    localparam logic [8:0] H_MAX = 9'(H);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [7:0]  len_q;      // latched number of words for this load
    logic [7:0]  word_idx;   // index of the word being assembled/written
    logic [1:0]  byte_idx;   // byte lane the next accepted byte lands in
    logic [31:0] word_q;     // word under assembly

    logic        len_ok;     // len_words is in 1..H
    logic        accept;     // byte handshake completes this cycle
    logic        last_byte;  // accepted byte completes the word
    logic        last_word;  // the word being written is the final one

    // Handshake and length qualifiers shared by the FSM and the datapath.
    assign len_ok    = (len_words != 8'd0) && ({1'b0, len_words} <= H_MAX);
    assign accept    = (state == RECV) && byte_valid;
    assign last_byte = accept && (byte_idx == 2'd3);
    assign last_word = ((word_idx + 8'd1) == len_q);

    // State register; synchronous reset wins over any start or handshake.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of block ordering.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and all outputs, which depend only on the current
    // state (plus program_counter passthrough while idle).
    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch
        // can leave one unassigned and infer a latch.
        state_next = state;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = 32'd0;
        mem_addr   = N'({word_idx, 2'b00});
        core_stall = 1'b1;
        busy       = 1'b1;
        done       = 1'b0;

        case (state)
            IDLE: begin
                mem_addr   = program_counter;
                core_stall = 1'b0;
                busy       = 1'b0;
                if (start && len_ok) begin
                    state_next = RECV;
                end
            end
            RECV: begin
                byte_ready = 1'b1;
                if (last_byte) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                mem_we    = 1'b1;
                mem_wdata = word_q;
                state_next = last_word ? DONE : RECV;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Load bookkeeping: length latch, error flag, byte packing and word
    // index advance. Idle cycles of the byte stream leave all of it alone.
    always_ff @(posedge clk) begin
        // NOTE: word_q is a single register rather than a memory array, so
        // clearing it on reset is cheap and keeps partial words from leaking.
        if (reset) begin
            len_q    <= 8'd0;
            word_idx <= 8'd0;
            byte_idx <= 2'd0;
            word_q   <= 32'd0;
            error    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            error    <= 1'b0;
                            len_q    <= len_words;
                            word_idx <= 8'd0;
                            byte_idx <= 2'd0;
                            word_q   <= 32'd0;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (accept) begin
                        word_q[{byte_idx, 3'b000} +: 8] <= byte_in;
                        byte_idx                        <= byte_idx + 2'd1;
                    end
                end
                WRITE: begin
                    // On the final word the index is kept so DONE still
                    // presents the last written address.
                    if (!last_word) begin
                        word_idx <= word_idx + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: normal load, illegal lengths, stalled
// byte stream, reset mid-word, start while busy and a full-depth load.
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  len_words;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [31:0] program_counter;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        core_stall;
    logic        busy;
    logic        done;
    logic        error;

    int          checks = 0;
    int          errors = 0;

    // Write/done log captured on the falling edge.
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          done_count = 0;

    imem_loader #(.N(32), .H(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .len_words       (len_words),
        .byte_in         (byte_in),
        .byte_valid      (byte_valid),
        .byte_ready      (byte_ready),
        .program_counter (program_counter),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_we          (mem_we),
        .core_stall      (core_stall),
        .busy            (busy),
        .done            (done),
        .error           (error)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record every memory write and done pulse, away from the active edge.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
        if (done === 1'b1) done_count++;
    end

    // Hard stop in case anything hangs.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        tick();
    endtask

    initial begin
        int          wr_base;
        int          done_base;
        int          n;
        int          bcnt;
        logic [31:0] exp_word;
        logic        pattern [7];
        logic [7:0]  stall_bytes [4];

        pattern     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        stall_bytes = '{8'h13, 8'h00, 8'h60, 8'h00};

        // ---- Reset, asserted together with a legal start (reset wins) ----
        reset           = 1'b1;
        start           = 1'b1;
        len_words       = 8'd1;
        byte_in         = 8'h00;
        byte_valid      = 1'b1;
        program_counter = 32'h0000_1234;
        tick();
        start      = 1'b0;
        byte_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check("rst_busy",   32'(busy),       32'd0);
        check("rst_stall",  32'(core_stall), 32'd0);
        check("rst_ready",  32'(byte_ready), 32'd0);
        check("rst_we",     32'(mem_we),     32'd0);
        check("rst_wdata",  mem_wdata,       32'd0);
        check("rst_done",   32'(done),       32'd0);
        check("rst_error",  32'(error),      32'd0);
        check("rst_addr",   mem_addr,        32'h0000_1234);

        // ---- Normal load: len=2, 13 00 60 00 93 00 10 00 ----
        start     = 1'b1;
        len_words = 8'd2;
        tick();
        start = 1'b0;
        check("n_recv_ready", 32'(byte_ready), 32'd1);
        check("n_recv_stall", 32'(core_stall), 32'd1);
        check("n_recv_busy",  32'(busy),       32'd1);
        check("n_recv_addr",  mem_addr,        32'h0);
        send(8'h13);
        send(8'h00);
        check("n_mid_wdata", mem_wdata,    32'd0);
        check("n_mid_we",    32'(mem_we),  32'd0);
        send(8'h60);
        send(8'h00);
        byte_valid = 1'b0;
        check("n_w0_we",    32'(mem_we),     32'd1);
        check("n_w0_addr",  mem_addr,        32'h0);
        check("n_w0_data",  mem_wdata,       32'h0060_0013);
        check("n_w0_ready", 32'(byte_ready), 32'd0);
        tick();
        check("n_r1_we",    32'(mem_we), 32'd0);
        check("n_r1_addr",  mem_addr,    32'h4);
        check("n_r1_wdata", mem_wdata,   32'd0);
        send(8'h93);
        send(8'h00);
        send(8'h10);
        send(8'h00);
        byte_valid = 1'b0;
        check("n_w1_we",   32'(mem_we), 32'd1);
        check("n_w1_addr", mem_addr,    32'h4);
        check("n_w1_data", mem_wdata,   32'h0010_0093);
        tick();
        check("n_done",       32'(done),       32'd1);
        check("n_done_stall", 32'(core_stall), 32'd1);
        check("n_done_we",    32'(mem_we),     32'd0);
        tick();
        check("n_idle_done",  32'(done),       32'd0);
        check("n_idle_stall", 32'(core_stall), 32'd0);
        check("n_idle_addr",  mem_addr,        32'h0000_1234);
        program_counter = 32'h0000_0080;
        #1;
        check("n_pc_follow", mem_addr, 32'h0000_0080);

        // ---- Illegal lengths: 0 and 17, then a legal len=1 ----
        wr_base = wr_addr_q.size();
        start     = 1'b1;
        len_words = 8'd0;
        tick();
        start = 1'b0;
        check("e0_error", 32'(error),      32'd1);
        check("e0_busy",  32'(busy),       32'd0);
        check("e0_stall", 32'(core_stall), 32'd0);
        start     = 1'b1;
        len_words = 8'd17;
        tick();
        start = 1'b0;
        check("e17_error", 32'(error),      32'd1);
        check("e17_stall", 32'(core_stall), 32'd0);
        tick();
        check("e_sticky",  32'(error),                   32'd1);
        check("e_nowrite", 32'(wr_addr_q.size() - wr_base), 32'd0);
        start     = 1'b1;
        len_words = 8'd1;
        tick();
        start = 1'b0;
        check("e_clear", 32'(error), 32'd0);
        check("e_busy",  32'(busy),  32'd1);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        send(8'h04);
        byte_valid = 1'b0;
        check("e_w_addr", mem_addr,  32'h0);
        check("e_w_data", mem_wdata, 32'h0403_0201);
        tick();
        tick();
        check("e_end_busy", 32'(busy), 32'd0);

        // ---- Stalled stream: valid pattern 1,0,0,1,1,0,1 ----
        start     = 1'b1;
        len_words = 8'd1;
        tick();
        start = 1'b0;
        bcnt  = 0;
        for (int i = 0; i < 7; i++) begin
            if (pattern[i]) begin
                byte_in = stall_bytes[bcnt];
                bcnt++;
            end else begin
                byte_in = 8'hFF;
            end
            byte_valid = pattern[i];
            tick();
            if (i < 6) check("s_no_early_we", 32'(mem_we), 32'd0);
        end
        byte_valid = 1'b0;
        check("s_we",   32'(mem_we), 32'd1);
        check("s_addr", mem_addr,    32'h0);
        check("s_data", mem_wdata,   32'h0060_0013);
        tick();
        tick();

        // ---- Reset mid-word (second word, two bytes in) ----
        start     = 1'b1;
        len_words = 8'd2;
        tick();
        start = 1'b0;
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        byte_valid = 1'b0;
        tick();
        wr_base = wr_addr_q.size();
        send(8'hAA);
        send(8'hBB);
        reset      = 1'b1;
        byte_in    = 8'hCC;
        byte_valid = 1'b1;
        tick();
        reset      = 1'b0;
        byte_valid = 1'b0;
        check("r_busy",  32'(busy),  32'd0);
        check("r_we",    32'(mem_we), 32'd0);
        check("r_addr",  mem_addr,   32'h0000_0080);
        tick();
        check("r_nowrite", 32'(wr_addr_q.size() - wr_base), 32'd0);
        start     = 1'b1;
        len_words = 8'd1;
        tick();
        start = 1'b0;
        send(8'h10);
        send(8'h32);
        send(8'h54);
        send(8'h76);
        byte_valid = 1'b0;
        check("r_w_we",   32'(mem_we), 32'd1);
        check("r_w_addr", mem_addr,    32'h0);
        check("r_w_data", mem_wdata,   32'h7654_3210);
        tick();
        tick();

        // ---- Start while busy: len=5 pulses during a len=1 load ----
        wr_base   = wr_addr_q.size();
        done_base = done_count;
        start     = 1'b1;
        len_words = 8'd1;
        tick();
        start = 1'b0;
        send(8'hA0);
        start     = 1'b1;
        len_words = 8'd5;
        send(8'hA1);
        start = 1'b0;
        send(8'hA2);
        send(8'hA3);
        start = 1'b1;        // WRITE cycle
        tick();
        start = 1'b0;        // DONE cycle
        byte_valid = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        byte_valid = 1'b0;
        check("b_busy",   32'(busy),                       32'd0);
        check("b_writes", 32'(wr_addr_q.size() - wr_base), 32'd1);
        check("b_dones",  32'(done_count - done_base),     32'd1);
        check("b_data",   wr_data_q[wr_base],              32'hA3A2_A1A0);

        // ---- Full depth: len=16 with byte_valid held high ----
        wr_base   = wr_addr_q.size();
        done_base = done_count;
        start     = 1'b1;
        len_words = 8'd16;
        tick();
        start = 1'b0;
        bcnt  = 0;
        n     = 0;
        while (done !== 1'b1 && n < 200) begin
            byte_in    = 8'(bcnt);
            byte_valid = 1'b1;
            if (byte_ready === 1'b1) bcnt++;
            tick();
            n++;
        end
        byte_valid = 1'b0;
        // Start cycle through done cycle spans 5*len+2 cycles inclusive,
        // i.e. 5*len edges after the one that accepts start.
        check("f_latency", 32'(n),    32'd80);
        check("f_done",    32'(done), 32'd1);
        check("f_writes",  32'(wr_addr_q.size() - wr_base), 32'd16);
        if (wr_addr_q.size() - wr_base == 16) begin
            for (int i = 0; i < 16; i++) begin
                exp_word = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
                check($sformatf("f_addr%0d", i), wr_addr_q[wr_base+i], 32'(4*i));
                check($sformatf("f_data%0d", i), wr_data_q[wr_base+i], exp_word);
            end
        end
        tick();
        check("f_done_pulse", 32'(done), 32'd0);
        check("f_idle_busy",  32'(busy), 32'd0);
        check("f_dones",      32'(done_count - done_base), 32'd1);
        program_counter = 32'h0000_0200;
        #1;
        check("f_pc_follow", mem_addr, 32'h0000_0200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
